// File: rtl/serial_deser_rx.sv
// Framed serial-to-parallel receiver: start bit, WIDTH data bits, optional even
// parity, stop bit. Samples the line only on bit-strobe (en) cycles.
module serial_deser_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_serial,
  input  logic             en,
  output logic [WIDTH-1:0] out_paralelo,
  output logic             valid,
  output logic             erro_paridade,
  output logic             erro_quadro,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_err_q, par_err_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic [WIDTH-1:0] shifted;

  assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], in_serial}
                             : {in_serial, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!in_serial) begin
            state_d   = S_DATA;
            cnt_d     = '0;
            par_err_d = 1'b0;
          end
        end
        S_DATA: begin
          shift_d = shifted;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          par_err_d = (^shift_q) ^ in_serial;
          state_d   = S_STOP;
        end
        S_STOP: begin
          if (in_serial) begin
            out_d   = shift_q;
            valid_d = 1'b1;
            perr_d  = PARITY_EN ? par_err_q : 1'b0;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          // A held-low break line must not be mistaken for fresh start bits.
          if (in_serial) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign out_paralelo  = out_q;
  assign valid         = valid_q;
  assign erro_paridade = perr_q;
  assign erro_quadro   = ferr_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_deser_rx.sv
// Bench for serial_deser_rx: two instances (MSB-first with parity, LSB-first
// without), frames built from the word-level rules and checked every cycle.
module tb_serial_deser_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in0, en0, in1, en1;
  logic [7:0] out0, out1;
  logic       v0, pe0, fe0, b0, v1, pe1, fe1, b1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  m_out  [2];
  logic        m_busy [2];

  serial_deser_rx #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_serial(in0), .en(en0), .out_paralelo(out0),
    .valid(v0), .erro_paridade(pe0), .erro_quadro(fe0), .busy(b0)
  );

  serial_deser_rx #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_serial(in1), .en(en1), .out_paralelo(out1),
    .valid(v1), .erro_paridade(pe1), .erro_quadro(fe1), .busy(b1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one clock cycle on the selected instance; the other one sits idle.
  task automatic step(input int sel, input logic e, input logic b);
    en0 = (sel == 0) ? e : 1'b0;
    in0 = (sel == 0) ? b : 1'b1;
    en1 = (sel == 1) ? e : 1'b0;
    in1 = (sel == 1) ? b : 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input int sel, input string tag,
                            input logic ev, input logic epe, input logic efe);
    logic [7:0] o;
    logic       v, pe, fe, b;
    if (sel == 0) begin o = out0; v = v0; pe = pe0; fe = fe0; b = b0; end
    else          begin o = out1; v = v1; pe = pe1; fe = fe1; b = b1; end
    check({tag, ".valid"}, 32'(v), 32'(ev));
    check({tag, ".erro_paridade"}, 32'(pe), 32'(epe));
    check({tag, ".erro_quadro"}, 32'(fe), 32'(efe));
    check({tag, ".busy"}, 32'(b), 32'(m_busy[sel]));
    check({tag, ".out"}, 32'(o), 32'(m_out[sel]));
  endtask

  task automatic idle(input int sel, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      logic e;
      e = 1'($urandom);
      step(sel, e, e ? 1'b1 : 1'($urandom));
      check_outs(sel, tag, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Frame-level reference: result depends only on word, parity bit, stop bit.
  task automatic send_frame(input int sel, input logic [7:0] word, input logic pbit,
                            input logic stop, input int period, input int brk,
                            input string tag);
    logic q[$];
    logic par_en, msb;
    par_en = (sel == 0);
    msb    = (sel == 0);
    q.push_back(1'b0);
    for (int k = 0; k < 8; k++) q.push_back(msb ? word[7-k] : word[k]);
    if (par_en) q.push_back(pbit);
    q.push_back(stop);
    for (int i = 0; i < q.size(); i++) begin
      for (int j = 1; j < period; j++) begin
        step(sel, 1'b0, 1'($urandom));
        check_outs(sel, tag, 1'b0, 1'b0, 1'b0);
      end
      step(sel, 1'b1, q[i]);
      if (i == 0) m_busy[sel] = 1'b1;
      if (i == q.size() - 1) begin
        if (stop) begin
          m_out[sel]  = word;
          m_busy[sel] = 1'b0;
          check_outs(sel, tag, 1'b1, par_en & ((^word) ^ pbit), 1'b0);
        end else begin
          check_outs(sel, tag, 1'b0, 1'b0, 1'b1);
        end
      end else begin
        check_outs(sel, tag, 1'b0, 1'b0, 1'b0);
      end
    end
    if (!stop) begin
      for (int i = 0; i < brk; i++) begin
        step(sel, 1'b1, 1'b0);
        check_outs(sel, {tag, ".break"}, 1'b0, 1'b0, 1'b0);
      end
      step(sel, 1'b1, 1'b1);
      m_busy[sel] = 1'b0;
      check_outs(sel, {tag, ".recover"}, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_out[s]  = '0;
      m_busy[s] = 1'b0;
      check_outs(s, "reset", 1'b0, 1'b0, 1'b0);
    end

    idle(0, 2, "idle0");
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1, 0, "a5_ok");
    idle(0, 1, "gap");
    send_frame(0, 8'hA5, 1'b1, 1'b1, 1, 0, "a5_perr");
    idle(0, 1, "gap");
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 5, "3c_ferr");

    // Reset in mid-frame: aborts with no flags and clears the output word.
    step(0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1);
    step(0, 1'b1, 1'b0);
    rst = 1'b1;
    step(0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0);
    rst = 1'b0;
    m_out[0]  = '0;
    m_busy[0] = 1'b0;
    check_outs(0, "midreset", 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1, 0, "after_rst");

    // Slow strobe on the LSB-first instance, with an en=0 glitch in IDLE.
    step(1, 1'b0, 1'b0);
    check_outs(1, "glitch", 1'b0, 1'b0, 1'b0);
    send_frame(1, 8'h81, 1'b0, 1'b1, 4, 0, "lsb_81");

    send_frame(0, 8'h12, 1'b0, 1'b1, 1, 0, "b2b_12");
    send_frame(0, 8'hFE, 1'b1, 1'b1, 1, 0, "b2b_fe");
    idle(0, 1, "after_b2b");

    for (int n = 0; n < 40; n++) begin
      int         sel;
      logic [7:0] w;
      logic       p, st;
      sel = n % 2;
      w   = 8'($urandom);
      p   = (^w) ^ ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 5) != 0);
      send_frame(sel, w, p, st, $urandom_range(1, 4), $urandom_range(0, 3), "rand");
      idle(sel, $urandom_range(0, 2), "rand_gap");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_deser_rx.md
Name: serial_deser_rx

Overview:
Framed serial-to-parallel receiver. It reassembles bytes shifted out one bit at a time by the team's shift-register datapath (SHL/SHR serial output) or by any single-wire source. It samples the line on bit-strobe cycles, checks the frame with start bit, WIDTH data bits, optional even parity and stop bit, then presents the word with status flags. It is the receiving end of the serial link driven by the shift-register block.

Parameters:
WIDTH, 8, number of data bits per frame (4..16)
MSB_FIRST, 1, 1 = first data bit received is the MSB (matches SHL output); 0 = LSB first (matches SHR output)
PARITY_EN, 1, 1 = one even-parity bit follows the data; 0 = no parity bit

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_serial  input  1  serial line, idles high
en  input  1  bit strobe; the line is sampled only on rising edges where en=1
out_paralelo  output  WIDTH  last correctly framed word
valid  output  1  one-cycle pulse: new word in out_paralelo
erro_paridade  output  1  one-cycle pulse alongside valid when the parity check failed
erro_quadro  output  1  one-cycle pulse: stop bit sampled as 0, frame discarded
busy  output  1  high while in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset, while rst=1 at a rising edge:
  - state returns to IDLE, bit counter and shift buffer are zeroed.
  - out_paralelo=0, valid=0, erro_paridade=0, erro_quadro=0, busy=0.
  - rst has priority over en; reset in mid-frame aborts the frame with no flags raised.
- FSM states: IDLE, DATA, PARITY, STOP, WAIT_IDLE.
- Cycles with en=0: no transition, no sampling, buffer and counter hold. Pulse outputs still deassert after one cycle.
- IDLE:
  - en=1 and in_serial=0 (start bit) -> DATA, counter=0.
  - en=1 and in_serial=1 -> stay in IDLE.
- DATA, on each en=1:
  - shift in_serial into the buffer. MSB_FIRST=1: buf={buf[WIDTH-2:0],in_serial}. MSB_FIRST=0: buf={in_serial,buf[WIDTH-1:1]}.
  - increment counter.
  - on the WIDTH-th bit -> PARITY if PARITY_EN=1, else STOP.
- PARITY, on en=1: store the bit; parity error = (^buf) ^ bit (even parity: ones in data plus parity bit must be even). Then -> STOP.
- STOP, on en=1:
  - in_serial=1: out_paralelo<=buf, valid<=1, erro_paridade<=parity error (0 when PARITY_EN=0), -> IDLE. Data is delivered even when parity fails.
  - in_serial=0: out_paralelo holds, erro_quadro<=1, -> WAIT_IDLE.
- WAIT_IDLE: stay until an en=1 sample with in_serial=1, then -> IDLE. This keeps a held-low (break) line from being read as repeated start bits.
- Latency: valid rises in the clock cycle after the rising edge that samples the stop bit.
- Back-to-back frames: a start bit on the en sample right after the stop bit is accepted (IDLE was reached on the stop edge).
- Flag pulses are exactly one clk cycle wide, independent of the en rate.
- busy=1 from the edge that accepts the start bit until the edge that leaves STOP or WAIT_IDLE.

Test Plan:
1. rst=1 for 2 cycles mid-frame, en=1 -> all outputs 0, busy=0; a following clean frame is still received correctly.
2. Defaults, en=1 every cycle, line 0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5 MSB first, parity 0, stop) -> out_paralelo=8'hA5, valid one cycle, erro_paridade=0, erro_quadro=0; valid high 11 cycles after the start sample edge +1.
3. Same frame with parity bit 1 -> out_paralelo=8'hA5, valid=1, erro_paridade=1 for one cycle.
4. Frame for 0x3C with stop bit 0 -> erro_quadro one cycle, out_paralelo keeps 8'hA5, busy stays 1. The line held 0 for 5 more samples causes no new frame; in_serial=1 then returns to IDLE.
5. MSB_FIRST=0, PARITY_EN=0, en high every 4th cycle, bits LSB first for 8'h81 -> out_paralelo=8'h81. Samples while en=0 are ignored, including a line glitch to 0 in IDLE.
6. Two frames 0x12 then 0xFE with no idle gap between them -> two valid pulses, 0x12 then 0xFE, no errors.
